// File: rtl/sram_uart_bus_controller_pkg.sv
// ---------------------------------------------------------------------------
// sram_uart_bus_controller_pkg
// Shared definitions for the SRAM/UART bus controller:
//   - data-port memory-control encodings (a_ctrl)
//   - bus-sequencer state enumeration
//   - default UART register addresses on the data port
//   - helper telling which states own the RAM1/UART data bus
// ---------------------------------------------------------------------------
package sram_uart_bus_controller_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        WS,
        WST,
        WH,
        UWS,
        UWST,
        UWH,
        URST,
        ST
    } state_t;

    // States in which the controller drives the shared RAM1/UART data bus.
    function automatic logic drives_bus(input state_t s);
        return (s inside {WS, WST, WH, UWS, UWST, UWH});
    endfunction

endpackage

// File: rtl/sram_uart_bus_controller_if.sv
// ---------------------------------------------------------------------------
// sram_uart_bus_controller_if
// Core-side bus between the CPU and the SRAM/UART bus controller.
//   a_addr  [15:0]  data-port address            (core -> ctrl)
//   a_wdata [15:0]  data-port write data         (core -> ctrl)
//   a_ctrl  [1:0]   00 none, 01 read, 10 write   (core -> ctrl)
//   a_rdata [15:0]  data-port read result        (ctrl -> core)
//   a_done          one-cycle read-complete pulse (ctrl -> core)
//   stall           freeze request to the core   (ctrl -> core)
//   b_addr  [15:0]  instruction-fetch address    (core -> ctrl)
//   b_rdata [15:0]  fetched instruction          (ctrl -> core)
// master = CPU core side, slave = controller side.
// ---------------------------------------------------------------------------
interface sram_uart_bus_controller_if;

    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_ctrl;
    logic [15:0] a_rdata;
    logic        a_done;
    logic        stall;
    logic [15:0] b_addr;
    logic [15:0] b_rdata;

    modport master (
        output a_addr, a_wdata, a_ctrl, b_addr,
        input  a_rdata, a_done, stall, b_rdata
    );

    modport slave (
        input  a_addr, a_wdata, a_ctrl, b_addr,
        output a_rdata, a_done, stall, b_rdata
    );

endinterface

// File: rtl/sram_uart_bus_controller_strobe_timer.sv
// ---------------------------------------------------------------------------
// sram_uart_bus_controller_strobe_timer
// Loadable 4-bit down-counter shared by every strobe-timed state.
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   i_load    in   load i_value this cycle (takes priority over counting)
//   i_value   in   [3:0] remaining cycles minus one
//   o_done    out  count has reached zero (current cycle is the last one)
// ---------------------------------------------------------------------------
module sram_uart_bus_controller_strobe_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_value,
    output logic       o_done
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/sram_uart_bus_controller.sv
// ---------------------------------------------------------------------------
// sram_uart_bus_controller
// Bridges the CPU data port (A) and instruction port (B) onto two async
// SRAMs and a byte UART that shares the RAM1 data bus.
//   clk, rst              clock, synchronous active-high reset
//   core (slave modport)  A/B core ports: request, read data, done, stall
//   ram1_addr/data        RAM1 (data memory) address and shared data bus
//   ram1_en/oe/we_n       RAM1 strobes, active-low
//   ram2_addr/data        RAM2 (instruction memory, read-only)
//   ram2_en/oe/we_n       RAM2 strobes, active-low
//   uart_rdn/wrn          UART strobes, active-low
//   uart_data_ready/tbre/tsre  UART status inputs
// ---------------------------------------------------------------------------
module sram_uart_bus_controller
    import sram_uart_bus_controller_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
    parameter logic [1:0]  ADDR_HI        = 2'b00,
    parameter int          STROBE_CYCLES  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    sram_uart_bus_controller_if.slave    core,
    output logic [17:0]                  ram1_addr,
    inout  wire  [15:0]                  ram1_data,
    output logic                         ram1_en_n,
    output logic                         ram1_oe_n,
    output logic                         ram1_we_n,
    output logic [17:0]                  ram2_addr,
    input  logic [15:0]                  ram2_data,
    output logic                         ram2_en_n,
    output logic                         ram2_oe_n,
    output logic                         ram2_we_n,
    output logic                         uart_rdn,
    output logic                         uart_wrn,
    input  logic                         uart_data_ready,
    input  logic                         uart_tbre,
    input  logic                         uart_tsre
);

    // Timer counts "remaining cycles minus one"; the UART read strobe is
    // held one cycle longer than the others to give the UART time to drive.
    localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] URD_LOAD     = 4'(STROBE_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_is_wr;
    logic [15:0] r_rdata;
    logic        r_done;
    logic [15:0] r_b_rdata;

    logic        w_req;
    logic        w_sel_data;
    logic        w_sel_stat;
    logic        w_tmr_load;
    logic [3:0]  w_tmr_value;
    logic        w_tmr_done;
    logic        w_last;
    logic        w_stall;
    logic        w_drive;
    logic [15:0] w_bus_out;

    assign w_req      = (core.a_ctrl == MEM_READ) || (core.a_ctrl == MEM_WRITE);
    assign w_sel_data = (core.a_addr == UART_DATA_ADDR);
    assign w_sel_stat = (core.a_addr == UART_STAT_ADDR);

    sram_uart_bus_controller_strobe_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    // Arm the timer on entry to any strobe-timed state.
    assign w_tmr_load  = (w_next != r_state) && (w_next inside {RD, WST, UWST, URST});
    assign w_tmr_value = (w_next == URST) ? URD_LOAD : STROBE_LOAD;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (core.a_ctrl == MEM_READ) begin
                        w_next = w_sel_data ? URST : (w_sel_stat ? ST : RD);
                    end else begin
                        // A write to the read-only status register is a
                        // one-cycle no-op that still completes cleanly.
                        w_next = w_sel_data ? UWS : (w_sel_stat ? ST : WS);
                    end
                end
            end
            RD:      if (w_tmr_done) w_next = IDLE;
            WS:      w_next = WST;
            WST:     if (w_tmr_done) w_next = WH;
            WH:      w_next = IDLE;
            UWS:     w_next = UWST;
            UWST:    if (w_tmr_done) w_next = UWH;
            UWH:     w_next = IDLE;
            URST:    if (w_tmr_done) w_next = IDLE;
            ST:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM: outputs. w_last marks the last cycle of a sequence, where the
    // core is released so it advances in step with the return to IDLE.
    always_comb begin
        ram1_en_n = 1'b1;
        ram1_oe_n = 1'b1;
        ram1_we_n = 1'b1;
        uart_rdn  = 1'b1;
        uart_wrn  = 1'b1;
        w_last    = 1'b0;
        w_drive   = drives_bus(r_state);
        w_bus_out = r_wdata;
        case (r_state)
            RD: begin
                ram1_en_n = 1'b0;
                ram1_oe_n = 1'b0;
                w_last    = w_tmr_done;
            end
            WS: ram1_en_n = 1'b0;
            WST: begin
                ram1_en_n = 1'b0;
                ram1_we_n = 1'b0;
            end
            WH: begin
                ram1_en_n = 1'b0;
                w_last    = 1'b1;
            end
            UWS:  w_bus_out = {8'h00, r_wdata[7:0]};
            UWST: begin
                uart_wrn  = 1'b0;
                w_bus_out = {8'h00, r_wdata[7:0]};
            end
            UWH: begin
                w_bus_out = {8'h00, r_wdata[7:0]};
                w_last    = 1'b1;
            end
            URST: begin
                uart_rdn = 1'b0;
                w_last   = w_tmr_done;
            end
            ST:      w_last = 1'b1;
            default: ;
        endcase
        w_stall = !rst && (((r_state == IDLE) && w_req) ||
                           ((r_state != IDLE) && !w_last));
    end

    // Request capture at the accepting edge; later a_* changes are ignored.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && w_req) begin
            r_addr  <= core.a_addr;
            r_wdata <= core.a_wdata;
            r_is_wr <= (core.a_ctrl == MEM_WRITE);
        end
    end

    // Read-data capture and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 16'h0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RD: if (w_tmr_done) begin
                    r_rdata <= ram1_data;
                    r_done  <= 1'b1;
                end
                URST: if (w_tmr_done) begin
                    r_rdata <= {8'h00, ram1_data[7:0]};
                    r_done  <= 1'b1;
                end
                ST: if (!r_is_wr) begin
                    r_rdata <= {14'b0, uart_data_ready, uart_tbre & uart_tsre};
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Instruction port: RAM2 permanently selected, one-cycle registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_rdata <= 16'h0000;
        end else begin
            r_b_rdata <= ram2_data;
        end
    end

    assign ram2_en_n = rst;
    assign ram2_oe_n = rst;
    assign ram2_we_n = 1'b1;
    assign ram2_addr = {ADDR_HI, core.b_addr};

    assign ram1_addr = {ADDR_HI, r_addr};
    assign ram1_data = w_drive ? w_bus_out : 16'hzzzz;

    assign core.a_rdata = r_rdata;
    assign core.a_done  = r_done;
    assign core.stall   = w_stall;
    assign core.b_rdata = r_b_rdata;

endmodule

// File: tb/tb_sram_uart_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_uart_bus_controller
// Directed bench for sram_uart_bus_controller with a RAM1 model, a RAM2
// model and a UART stub sharing the RAM1 bus. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. A weak "probe" value
// (16'h5A5A) is placed on the shared bus in windows where the controller
// must have released it, so any controller drive corrupts the value seen.
// ---------------------------------------------------------------------------
module tb_sram_uart_bus_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_uart_bus_controller_if bus ();

    logic [17:0] ram1_addr;
    wire  [15:0] ram1_data;
    logic        ram1_en_n, ram1_oe_n, ram1_we_n;
    logic [17:0] ram2_addr;
    logic [15:0] ram2_data;
    logic        ram2_en_n, ram2_oe_n, ram2_we_n;
    logic        uart_rdn, uart_wrn;
    logic        uart_data_ready, uart_tbre, uart_tsre;

    sram_uart_bus_controller #(
        .UART_DATA_ADDR (16'hBF00),
        .UART_STAT_ADDR (16'hBF01),
        .ADDR_HI        (2'b00),
        .STROBE_CYCLES  (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core            (bus),
        .ram1_addr       (ram1_addr),
        .ram1_data       (ram1_data),
        .ram1_en_n       (ram1_en_n),
        .ram1_oe_n       (ram1_oe_n),
        .ram1_we_n       (ram1_we_n),
        .ram2_addr       (ram2_addr),
        .ram2_data       (ram2_data),
        .ram2_en_n       (ram2_en_n),
        .ram2_oe_n       (ram2_oe_n),
        .ram2_we_n       (ram2_we_n),
        .uart_rdn        (uart_rdn),
        .uart_wrn        (uart_wrn),
        .uart_data_ready (uart_data_ready),
        .uart_tbre       (uart_tbre),
        .uart_tsre       (uart_tsre)
    );

    // RAM1 model: 256 words, preloaded word 0x10 while in reset.
    logic [15:0] mem1 [0:255];
    logic        probe;
    logic        tb_en;
    logic [15:0] tb_val;

    always @(posedge clk) begin
        if (rst) begin
            mem1[8'h10] <= 16'h1234;
        end else if (!ram1_en_n && !ram1_we_n) begin
            mem1[ram1_addr[7:0]] <= ram1_data;
        end
    end

    always_comb begin
        tb_en  = 1'b0;
        tb_val = 16'h0000;
        if (!ram1_en_n && !ram1_oe_n) begin
            tb_en  = 1'b1;
            tb_val = mem1[ram1_addr[7:0]];
        end else if (!uart_rdn) begin
            tb_en  = 1'b1;
            tb_val = 16'hAB5A;
        end else if (probe) begin
            tb_en  = 1'b1;
            tb_val = 16'h5A5A;
        end
    end

    assign ram1_data = tb_en ? tb_val : 16'hzzzz;

    // RAM2 model: word = 0xC000 ^ address.
    assign ram2_data = (!ram2_en_n && !ram2_oe_n) ? (16'hC000 ^ ram2_addr[15:0]) : 16'hDEAD;

    int n_chk;
    int n_bad;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        probe = 1'b1;
        bus.a_ctrl  = 2'b10;
        bus.a_addr  = 16'h0020;
        bus.a_wdata = 16'h1111;
        bus.b_addr  = 16'h0003;
        uart_data_ready = 1'b0;
        uart_tbre = 1'b0;
        uart_tsre = 1'b0;

        // Reset held with a write request pending.
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("rst_en_n",    16'(ram1_en_n), 16'd1);
            chk("rst_oe_n",    16'(ram1_oe_n), 16'd1);
            chk("rst_we_n",    16'(ram1_we_n), 16'd1);
            chk("rst_rdn",     16'(uart_rdn),  16'd1);
            chk("rst_wrn",     16'(uart_wrn),  16'd1);
            chk("rst_r2_en_n", 16'(ram2_en_n), 16'd1);
            chk("rst_r2_oe_n", 16'(ram2_oe_n), 16'd1);
            chk("rst_stall",   16'(bus.stall), 16'd0);
            chk("rst_done",    16'(bus.a_done), 16'd0);
            chk("rst_rdata",   bus.a_rdata, 16'h0000);
            chk("rst_b_rdata", bus.b_rdata, 16'h0000);
            chk("rst_bus_z",   ram1_data, 16'h5A5A);
            cyc();
        end
        rst = 1'b0;
        bus.a_ctrl = 2'b00;
        probe = 1'b0;
        smp();
        chk("idle_stall",    16'(bus.stall), 16'd0);
        chk("idle_r2_en_n",  16'(ram2_en_n), 16'd0);
        chk("idle_r2_oe_n",  16'(ram2_oe_n), 16'd0);
        chk("idle_r2_we_n",  16'(ram2_we_n), 16'd1);

        // RAM read of 0x0010.
        cyc(); bus.a_ctrl = 2'b01; bus.a_addr = 16'h0010;
        smp();
        chk("rd0_stall", 16'(bus.stall), 16'd1);
        chk("rd0_oe_n",  16'(ram1_oe_n), 16'd1);
        cyc();
        smp();
        chk("rd1_stall", 16'(bus.stall), 16'd0);
        chk("rd1_oe_n",  16'(ram1_oe_n), 16'd0);
        chk("rd1_en_n",  16'(ram1_en_n), 16'd0);
        chk("rd1_addr",  ram1_addr[15:0], 16'h0010);
        chk("rd1_addr_hi", 16'(ram1_addr[17:16]), 16'd0);
        cyc(); bus.a_ctrl = 2'b00;
        smp();
        chk("rd2_done",  16'(bus.a_done), 16'd1);
        chk("rd2_rdata", bus.a_rdata, 16'h1234);
        chk("rd2_oe_n",  16'(ram1_oe_n), 16'd1);
        cyc();
        smp();
        chk("rd3_done",  16'(bus.a_done), 16'd0);
        chk("rd3_hold",  bus.a_rdata, 16'h1234);

        // RAM write 0xBEEF -> 0x0020 with a concurrent B-port sweep.
        cyc(); bus.a_ctrl = 2'b10; bus.a_addr = 16'h0020; bus.a_wdata = 16'hBEEF;
        smp();
        chk("wr0_stall", 16'(bus.stall), 16'd1);
        chk("wr0_we_n",  16'(ram1_we_n), 16'd1);
        chk("wr0_b",     bus.b_rdata, 16'hC003);
        cyc(); bus.b_addr = 16'h0000;
        smp();
        chk("ws_en_n",   16'(ram1_en_n), 16'd0);
        chk("ws_we_n",   16'(ram1_we_n), 16'd1);
        chk("ws_bus",    ram1_data, 16'hBEEF);
        chk("ws_stall",  16'(bus.stall), 16'd1);
        chk("ws_b",      bus.b_rdata, 16'hC003);
        cyc(); bus.b_addr = 16'h0001;
        smp();
        chk("wst_we_n",  16'(ram1_we_n), 16'd0);
        chk("wst_bus",   ram1_data, 16'hBEEF);
        chk("wst_stall", 16'(bus.stall), 16'd1);
        chk("wst_b",     bus.b_rdata, 16'hC000);
        cyc(); bus.b_addr = 16'h0002;
        smp();
        chk("wh_we_n",   16'(ram1_we_n), 16'd1);
        chk("wh_bus",    ram1_data, 16'hBEEF);
        chk("wh_stall",  16'(bus.stall), 16'd0);
        chk("wh_done",   16'(bus.a_done), 16'd0);
        chk("wh_b",      bus.b_rdata, 16'hC001);
        cyc(); bus.a_ctrl = 2'b00;
        smp();
        chk("wr_end_we_n", 16'(ram1_we_n), 16'd1);
        chk("wr_end_en_n", 16'(ram1_en_n), 16'd1);
        chk("wr_end_done", 16'(bus.a_done), 16'd0);
        chk("wr_end_b",    bus.b_rdata, 16'hC002);
        chk("wr_mem",      mem1[8'h20], 16'hBEEF);

        // UART write: only the low byte goes on the bus.
        cyc(); bus.a_ctrl = 2'b10; bus.a_addr = 16'hBF00; bus.a_wdata = 16'h1241;
        smp();
        chk("uw0_stall", 16'(bus.stall), 16'd1);
        cyc();
        smp();
        chk("uws_en_n",  16'(ram1_en_n), 16'd1);
        chk("uws_wrn",   16'(uart_wrn),  16'd1);
        chk("uws_bus",   ram1_data, 16'h0041);
        cyc();
        smp();
        chk("uwst_wrn",  16'(uart_wrn),  16'd0);
        chk("uwst_en_n", 16'(ram1_en_n), 16'd1);
        chk("uwst_we_n", 16'(ram1_we_n), 16'd1);
        chk("uwst_bus",  ram1_data, 16'h0041);
        chk("uwst_stall",16'(bus.stall), 16'd1);
        cyc();
        smp();
        chk("uwh_wrn",   16'(uart_wrn), 16'd1);
        chk("uwh_bus",   ram1_data, 16'h0041);
        chk("uwh_stall", 16'(bus.stall), 16'd0);

        // Back-to-back status read: tbre=tsre=1, data_ready=0.
        cyc(); bus.a_ctrl = 2'b01; bus.a_addr = 16'hBF01;
        uart_tbre = 1'b1; uart_tsre = 1'b1; uart_data_ready = 1'b0;
        smp();
        chk("st0_stall", 16'(bus.stall), 16'd1);
        chk("st0_done",  16'(bus.a_done), 16'd0);
        cyc();
        smp();
        chk("st_stall",  16'(bus.stall), 16'd0);
        chk("st_en_n",   16'(ram1_en_n), 16'd1);
        cyc(); bus.a_ctrl = 2'b00;
        smp();
        chk("st_done",   16'(bus.a_done), 16'd1);
        chk("st_rdata",  bus.a_rdata, 16'h0001);

        // Status read: data_ready=1, transmitter still busy.
        cyc(); bus.a_ctrl = 2'b01; bus.a_addr = 16'hBF01;
        uart_data_ready = 1'b1; uart_tsre = 1'b0;
        smp();
        cyc();
        smp();
        cyc(); bus.a_ctrl = 2'b00;
        smp();
        chk("st2_done",  16'(bus.a_done), 16'd1);
        chk("st2_rdata", bus.a_rdata, 16'h0002);

        // UART read: rdn held two cycles, high byte masked.
        cyc(); bus.a_ctrl = 2'b01; bus.a_addr = 16'hBF00;
        smp();
        chk("ur0_stall", 16'(bus.stall), 16'd1);
        chk("ur0_rdn",   16'(uart_rdn), 16'd1);
        cyc();
        smp();
        chk("ur1_rdn",   16'(uart_rdn), 16'd0);
        chk("ur1_en_n",  16'(ram1_en_n), 16'd1);
        chk("ur1_stall", 16'(bus.stall), 16'd1);
        cyc();
        smp();
        chk("ur2_rdn",   16'(uart_rdn), 16'd0);
        chk("ur2_stall", 16'(bus.stall), 16'd0);
        chk("ur2_done",  16'(bus.a_done), 16'd0);
        cyc(); bus.a_ctrl = 2'b00;
        smp();
        chk("ur3_rdn",   16'(uart_rdn), 16'd1);
        chk("ur3_done",  16'(bus.a_done), 16'd1);
        chk("ur3_rdata", bus.a_rdata, 16'h005A);

        // Reset asserted during WST aborts the write.
        cyc(); bus.a_ctrl = 2'b10; bus.a_addr = 16'h0030; bus.a_wdata = 16'h5555;
        smp();
        cyc();
        smp();
        cyc();
        smp();
        chk("ab_wst_we_n", 16'(ram1_we_n), 16'd0);
        rst = 1'b1;
        cyc(); rst = 1'b0; bus.a_ctrl = 2'b00; probe = 1'b1;
        smp();
        chk("ab_we_n",   16'(ram1_we_n), 16'd1);
        chk("ab_en_n",   16'(ram1_en_n), 16'd1);
        chk("ab_bus_z",  ram1_data, 16'h5A5A);
        chk("ab_stall",  16'(bus.stall), 16'd0);
        chk("ab_done",   16'(bus.a_done), 16'd0);
        chk("ab_rdata",  bus.a_rdata, 16'h0000);
        cyc(); probe = 1'b0;
        smp();
        chk("ab_done2",  16'(bus.a_done), 16'd0);

        // Controller is usable again after the abort.
        cyc(); bus.a_ctrl = 2'b01; bus.a_addr = 16'h0020;
        smp();
        chk("rec0_stall", 16'(bus.stall), 16'd1);
        cyc();
        smp();
        cyc(); bus.a_ctrl = 2'b00;
        smp();
        chk("rec_done",  16'(bus.a_done), 16'd1);
        chk("rec_rdata", bus.a_rdata, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
